// File: rtl/router_ingress_queue.sv
// Ingress FIFO in front of the 4-port address router.
// Words drain strictly in order onto registered din/din_en/addr, gated by the head entry's port stall.
module router_ingress_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic [1:0]                     in_addr,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [3:0]                     port_stall,
   output logic [DATA_WIDTH-1:0]          din,
   output logic                           din_en,
   output logic [1:0]                     addr,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   // Handshake: a word moves on any rising edge where in_valid && in_ready.
   // in_ready depends on the count register only, never on in_valid or a same-cycle pop.

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
   logic [1:0]            addr_mem_q [DEPTH];
   logic [1:0]            addr_mem_d [DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [1:0]            addr_q, addr_d;
   logic                  din_en_q, din_en_d;

   logic [1:0]            head_addr;
   logic                  push;
   logic                  pop;

   assign in_ready = (count_q != FULL);
   assign din      = din_q;
   assign din_en   = din_en_q;
   assign addr     = addr_q;
   assign count    = count_q;

   always_comb begin
      data_mem_d = data_mem_q;
      addr_mem_d = addr_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      din_d      = '0;
      addr_d     = '0;
      din_en_d   = 1'b0;

      head_addr  = addr_mem_q[rd_ptr_q];
      push       = in_valid && in_ready;
      // Only the head's destination is consulted: a stalled head blocks everything behind it.
      pop        = (count_q != '0) && !port_stall[head_addr];

      if (push) begin
         data_mem_d[wr_ptr_q] = in_data;
         addr_mem_d[wr_ptr_q] = in_addr;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end

      if (pop) begin
         din_d    = data_mem_q[rd_ptr_q];
         addr_d   = head_addr;
         din_en_d = 1'b1;
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         din_q    <= '0;
         addr_q   <= '0;
         din_en_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         din_q    <= din_d;
         addr_q   <= addr_d;
         din_en_q <= din_en_d;
      end
   end

   // Storage is never read while count is zero, so it needs no reset; writes are ignored in reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_mem_q <= data_mem_d;
         addr_mem_q <= addr_mem_d;
      end
   end

endmodule

// File: tb/tb_router_ingress_queue.sv
// Self-checking bench for router_ingress_queue: scoreboard of pushed words checked against din/addr.
module tb_router_ingress_queue;

   localparam int DW = 32;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic [DW-1:0] in_data;
   logic [1:0]    in_addr;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    port_stall;
   logic [DW-1:0] din;
   logic          din_en;
   logic [1:0]    addr;
   logic [2:0]    count;

   logic [DW+1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   logic mon_en = 1'b0;
   int run_len  = 0;
   int max_run  = 0;

   router_ingress_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_addr(in_addr),
      .in_valid(in_valid), .in_ready(in_ready), .port_stall(port_stall),
      .din(din), .din_en(din_en), .addr(addr), .count(count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (mon_en) begin
         if (din_en === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_word", {32'h0, din}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               logic [DW+1:0] e;
               e = exp_q.pop_front();
               check_eq("din", 64'(din), 64'(e[DW-1:0]));
               check_eq("addr", 64'(addr), 64'(e[DW+1:DW]));
            end
         end else begin
            run_len = 0;
            check_eq("idle_outputs_zero", {29'h0, din_en, addr, din}, 64'h0);
         end
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic push_one(input logic [1:0] a, input logic [DW-1:0] d);
      int budget;
      budget = 200;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_addr  = a;
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check_eq("push_timeout", 64'h0, 64'h1);
      exp_q.push_back({a, d});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drained;
      int budget;
      budget = 200;
      while ((count != 0 || exp_q.size() != 0) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("drain_timeout", 64'(budget == 0), 64'h0);
      idle_cycles(2);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0; port_stall = 4'h0;
      idle_cycles(3);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_din_en", 64'(din_en), 64'h0);
      check_eq("rst_din", 64'(din), 64'h0);
      check_eq("rst_count", 64'(count), 64'h0);
      check_eq("rst_in_ready", 64'(in_ready), 64'h1);
      mon_en = 1'b1;

      // 1: single word latency, no bypass
      push_one(2'd2, 32'hDEAD_BEEF);
      @(negedge clk);
      check_eq("t1_after_t_din_en", 64'(din_en), 64'h0);
      check_eq("t1_after_t_count", 64'(count), 64'h1);
      @(negedge clk);
      check_eq("t1_after_t1_din_en", 64'(din_en), 64'h1);
      check_eq("t1_after_t1_count", 64'(count), 64'h0);
      @(negedge clk);
      check_eq("t1_after_t2_din_en", 64'(din_en), 64'h0);

      // 2: fill while fully stalled, refuse 5th, drain
      port_stall = 4'hF;
      for (int i = 0; i < 4; i++) push_one(2'(i), 32'h10 + 32'(i));
      @(negedge clk);
      check_eq("t2_full_count", 64'(count), 64'h4);
      check_eq("t2_full_in_ready", 64'(in_ready), 64'h0);
      in_valid = 1'b1; in_data = 32'h14; in_addr = 2'd0;
      idle_cycles(2);
      in_valid = 1'b0;
      check_eq("t2_refused_count", 64'(count), 64'h4);
      port_stall = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("t2_drain_din_en", 64'(din_en), 64'h1);
      end
      @(negedge clk);
      check_eq("t2_after_drain_din_en", 64'(din_en), 64'h0);
      check_eq("t2_empty_count", 64'(count), 64'h0);

      // 3: head-of-line blocking
      port_stall = 4'b0010;
      push_one(2'd1, 32'hA1);
      push_one(2'd3, 32'hB3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("t3_blocked_din_en", 64'(din_en), 64'h0);
      end
      check_eq("t3_blocked_count", 64'(count), 64'h2);
      port_stall = 4'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("t3_release_din_en", 64'(din_en), 64'h1);
      end
      wait_drained();

      // 4: simultaneous push and pop at count 2
      port_stall = 4'hF;
      push_one(2'd0, 32'h40);
      push_one(2'd1, 32'h41);
      @(negedge clk);
      port_stall = 4'h0;
      in_valid = 1'b1; in_data = 32'h42; in_addr = 2'd2;
      exp_q.push_back({2'd2, 32'h42});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check_eq("t4_pushpop_count", 64'(count), 64'h2);
      check_eq("t4_pushpop_in_ready", 64'(in_ready), 64'h1);
      wait_drained();

      // 5: reset discards queued words
      port_stall = 4'hF;
      for (int i = 0; i < 3; i++) push_one(2'(i), 32'h50 + 32'(i));
      @(negedge clk);
      check_eq("t5_count_before", 64'(count), 64'h3);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      check_eq("t5_rst_count", 64'(count), 64'h0);
      check_eq("t5_rst_din_en", 64'(din_en), 64'h0);
      check_eq("t5_rst_in_ready", 64'(in_ready), 64'h1);
      port_stall = 4'h0;
      idle_cycles(6);

      // 6: stream of 10 across pointer wrap, random idle gap before it
      idle_cycles($urandom_range(1, 3));
      max_run = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("t6_in_ready", 64'(in_ready), 64'h1);
         in_valid = 1'b1; in_data = 32'(i); in_addr = 2'(i % 4);
         exp_q.push_back({2'(i % 4), 32'(i)});
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
      wait_drained();
      check_eq("t6_run_length", 64'(max_run), 64'd10);
      check_eq("final_sb_empty", 64'(exp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
